// File: rtl/dct2_pkg.sv
// Shared constants and types for the dct2_1d_pipe 4/8-point integer DCT-II pipeline.
package dct2_pkg;

    localparam int DEFAULT_IW = 19;

    // HEVC-style integer DCT basis coefficients
    localparam int C64 = 64;
    localparam int C83 = 83;
    localparam int C36 = 36;
    localparam int C89 = 89;
    localparam int C75 = 75;
    localparam int C50 = 50;
    localparam int C18 = 18;

    typedef logic size_t;  // 1 = 8-point vector, 0 = 4-point vector

endpackage

// File: rtl/dct2_1d_pipe_sau_8o.sv
// sau_8o: shift-add products 89x, 75x, 50x and 18x of one odd-part input.
module sau_8o
    import dct2_pkg::*;
#(
    parameter int W = DEFAULT_IW + 10
) (
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] p89,
    output logic signed [W-1:0] p75,
    output logic signed [W-1:0] p50,
    output logic signed [W-1:0] p18
);

    assign p89 = (x <<< 6) + (x <<< 4) + (x <<< 3) + x;
    assign p75 = (x <<< 6) + (x <<< 3) + (x <<< 1) + x;
    assign p50 = (x <<< 5) + (x <<< 4) + (x <<< 1);
    assign p18 = (x <<< 4) + (x <<< 1);

endmodule

// File: rtl/dct2_1d_pipe.sv
// dct2_1d_pipe: 3-stage 4/8-point 1-D integer DCT-II with valid/ready flow control.
// Optional macro DCT2_ROUND_SHIFT_EN adds a rounding right shift by SHIFT on the outputs.
module dct2_1d_pipe
    import dct2_pkg::*;
#(
    parameter int IW    = DEFAULT_IW,
    parameter int OW    = IW + 10,
    parameter int SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_size8,
    input  logic signed [IW-1:0] in_x [8],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_size8,
    output logic signed [OW-1:0] out_y [8]
);

    generate
        if (OW < IW + 10) begin : g_ow_chk
            $error("dct2_1d_pipe: OW must be at least IW+10");
        end
`ifdef DCT2_ROUND_SHIFT_EN
        if (SHIFT < 1) begin : g_shift_chk
            $error("dct2_1d_pipe: SHIFT must be at least 1");
        end
`endif
    endgenerate

    function automatic logic signed [OW-1:0] mul83(input logic signed [OW-1:0] v);
        return (v <<< 6) + (v <<< 4) + (v <<< 1) + v;
    endfunction

    function automatic logic signed [OW-1:0] mul36(input logic signed [OW-1:0] v);
        return (v <<< 5) + (v <<< 2);
    endfunction

    logic                 advance;
    logic signed [OW-1:0] xs     [8];
    logic signed [OW-1:0] e_in   [4];
    logic signed [OW-1:0] o_in   [4];

    logic                 s1_valid_q, s1_valid_d;
    size_t                s1_size_q,  s1_size_d;
    logic signed [OW-1:0] e_q [4], e_d [4];
    logic signed [OW-1:0] o_q [4], o_d [4];

    logic signed [OW-1:0] a0, a1, b0, b1;
    logic signed [OW-1:0] ev_in   [6];
    logic signed [OW-1:0] od_prod [16];
    logic                 s2_valid_q, s2_valid_d;
    size_t                s2_size_q,  s2_size_d;
    logic signed [OW-1:0] ev_q [6],  ev_d [6];
    logic signed [OW-1:0] od_q [16], od_d [16];

    logic signed [OW-1:0] y_raw [8];
    logic signed [OW-1:0] y_fin [8];
    logic                 s3_valid_q, s3_valid_d;
    size_t                s3_size_q,  s3_size_d;
    logic signed [OW-1:0] y_q [8], y_d [8];

    assign advance   = !s3_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid_q;
    assign out_size8 = s3_size_q;
    assign out_y     = y_q;

    // S1 input: butterflies; in 4-point mode only lanes 0..1 carry data
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sext
            assign xs[gi] = {{(OW-IW){in_x[gi][IW-1]}}, in_x[gi]};
        end
        for (gi = 0; gi < 4; gi++) begin : g_s1
            if (gi < 2) begin : g_lo
                assign e_in[gi] = in_size8 ? xs[gi] + xs[7-gi] : xs[gi] + xs[3-gi];
                assign o_in[gi] = in_size8 ? xs[gi] - xs[7-gi] : xs[gi] - xs[3-gi];
            end else begin : g_hi
                assign e_in[gi] = in_size8 ? xs[gi] + xs[7-gi] : '0;
                assign o_in[gi] = in_size8 ? xs[gi] - xs[7-gi] : '0;
            end
        end
    endgenerate

    // The 4-point even/odd parts reuse the 8-point even-even/even-odd datapath
    assign a0 = s1_size_q ? e_q[0] + e_q[3] : e_q[0];
    assign a1 = s1_size_q ? e_q[1] + e_q[2] : e_q[1];
    assign b0 = s1_size_q ? e_q[0] - e_q[3] : o_q[0];
    assign b1 = s1_size_q ? e_q[1] - e_q[2] : o_q[1];

    assign ev_in[0] = a0 <<< 6;
    assign ev_in[1] = a1 <<< 6;
    assign ev_in[2] = mul83(b0);
    assign ev_in[3] = mul36(b0);
    assign ev_in[4] = mul83(b1);
    assign ev_in[5] = mul36(b1);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_sau
            sau_8o #(.W(OW)) u_sau (
                .x   (o_q[gi]),
                .p89 (od_prod[gi*4+0]),
                .p75 (od_prod[gi*4+1]),
                .p50 (od_prod[gi*4+2]),
                .p18 (od_prod[gi*4+3])
            );
        end
    endgenerate

    // od_q index = 4*i + k with k: 0=89, 1=75, 2=50, 3=18 applied to O[i]
    always_comb begin
        y_raw = '{default: '0};
        if (s2_size_q) begin
            y_raw[0] = ev_q[0] + ev_q[1];
            y_raw[4] = ev_q[0] - ev_q[1];
            y_raw[2] = ev_q[2] + ev_q[5];
            y_raw[6] = ev_q[3] - ev_q[4];
            y_raw[1] = od_q[0] + od_q[5] + od_q[10] + od_q[15];
            y_raw[3] = od_q[1] - od_q[7] - od_q[8]  - od_q[14];
            y_raw[5] = od_q[2] - od_q[4] + od_q[11] + od_q[13];
            y_raw[7] = od_q[3] - od_q[6] + od_q[9]  - od_q[12];
        end else begin
            y_raw[0] = ev_q[0] + ev_q[1];
            y_raw[1] = ev_q[2] + ev_q[5];
            y_raw[2] = ev_q[0] - ev_q[1];
            y_raw[3] = ev_q[3] - ev_q[4];
        end
    end

`ifdef DCT2_ROUND_SHIFT_EN
    localparam logic signed [OW-1:0] RND = OW'(1) << (SHIFT - 1);
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rnd
            assign y_fin[gi] = (y_raw[gi] + RND) >>> SHIFT;
        end
    endgenerate
`else
    assign y_fin = y_raw;
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_size_d  = s1_size_q;
        e_d        = e_q;
        o_d        = o_q;
        s2_valid_d = s2_valid_q;
        s2_size_d  = s2_size_q;
        ev_d       = ev_q;
        od_d       = od_q;
        s3_valid_d = s3_valid_q;
        s3_size_d  = s3_size_q;
        y_d        = y_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_size_d  = in_size8;
            e_d        = e_in;
            o_d        = o_in;
            s2_valid_d = s1_valid_q;
            s2_size_d  = s1_size_q;
            ev_d       = ev_in;
            od_d       = od_prod;
            s3_valid_d = s2_valid_q;
            s3_size_d  = s2_size_q;
            y_d        = y_fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_size_q  <= 1'b0;
            e_q        <= '{default: '0};
            o_q        <= '{default: '0};
            s2_valid_q <= 1'b0;
            s2_size_q  <= 1'b0;
            ev_q       <= '{default: '0};
            od_q       <= '{default: '0};
            s3_valid_q <= 1'b0;
            s3_size_q  <= 1'b0;
            y_q        <= '{default: '0};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_size_q  <= s1_size_d;
            e_q        <= e_d;
            o_q        <= o_d;
            s2_valid_q <= s2_valid_d;
            s2_size_q  <= s2_size_d;
            ev_q       <= ev_d;
            od_q       <= od_d;
            s3_valid_q <= s3_valid_d;
            s3_size_q  <= s3_size_d;
            y_q        <= y_d;
        end
    end

endmodule

// File: tb/tb_dct2_1d_pipe.sv
// Self-checking bench for dct2_1d_pipe: directed vectors, stalled stream, reset mid-flight.
module tb_dct2_1d_pipe;

    localparam int IW    = 19;
    localparam int OW    = IW + 10;
    localparam int SHIFT = 2;
    localparam int NS    = 12;

    localparam int C8 [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };
    localparam int C4 [4][4] = '{
        '{64,  64,  64,  64},
        '{83,  36, -36, -83},
        '{64, -64, -64,  64},
        '{36, -83,  83, -36}
    };

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_size8;
    logic signed [IW-1:0] in_x [8];
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_size8;
    logic signed [OW-1:0] out_y [8];

    int n_checks = 0;
    int n_fail   = 0;

    int     xv [8];
    longint ev [8];
    int     sv [NS][8];
    logic   q_sz [$];
    longint q_y  [$];

    dct2_1d_pipe #(.IW(IW), .OW(OW), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_size8  (in_size8),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_size8 (out_size8),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint rnd(input longint v);
`ifdef DCT2_ROUND_SHIFT_EN
        return (v + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`else
        return v;
`endif
    endfunction

    task automatic model(input logic sz, input int x [8], output longint y [8]);
        for (int k = 0; k < 8; k++) begin
            y[k] = 0;
            if (sz) begin
                for (int n = 0; n < 8; n++) y[k] += longint'(C8[k][n]) * longint'(x[n]);
            end else if (k < 4) begin
                for (int n = 0; n < 4; n++) y[k] += longint'(C4[k][n]) * longint'(x[n]);
            end
            y[k] = rnd(y[k]);
        end
    endtask

    task automatic run_one(input string tag, input logic sz, input int x [8], input longint ex [8]);
        int cyc;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_size8 = sz;
        for (int i = 0; i < 8; i++) in_x[i] = IW'(x[i]);
        check_eq({tag, "_in_ready"}, longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, cyc, 3);
        check_eq({tag, "_size8"}, longint'(out_size8), longint'(sz));
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("%s_y%0d", tag, i), longint'(out_y[i]), ex[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     nsent, nrecv, cyc, stale;
        int     xa [8];
        longint ya [8];
        longint held [8];
        bit     was_stall;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_size8  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_x[i] = '0;
        for (int v = 0; v < NS; v++)
            for (int i = 0; i < 8; i++)
                sv[v][i] = int'($urandom_range((1 << IW) - 1, 0)) - (1 << (IW - 1));

        #2 rst_n = 1'b0;
        #10;
        check_eq("rst_out_valid", longint'(out_valid), 0);
        check_eq("rst_in_ready", longint'(in_ready), 1);
        check_eq("rst_out_size8", longint'(out_size8), 0);
        for (int i = 0; i < 8; i++) check_eq($sformatf("rst_y%0d", i), longint'(out_y[i]), 0);
        @(negedge clk) rst_n = 1'b1;

        // 4-point [1,2,3,4]
        xv = '{1, 2, 3, 4, 0, 0, 0, 0};
        ev = '{640, -285, 0, -25, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) ev[i] = rnd(ev[i]);
        run_one("s4_1234", 1'b0, xv, ev);

        // 8-point impulse gives the first basis column
        xv = '{1, 0, 0, 0, 0, 0, 0, 0};
        ev = '{64, 89, 83, 75, 64, 50, 36, 18};
        for (int i = 0; i < 8; i++) ev[i] = rnd(ev[i]);
        run_one("s8_imp", 1'b1, xv, ev);

        // 8-point DC
        xv = '{1, 1, 1, 1, 1, 1, 1, 1};
        ev = '{512, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) ev[i] = rnd(ev[i]);
        run_one("s8_dc", 1'b1, xv, ev);

        // Extremes: all minimum, alternating max/min, both sizes
        for (int i = 0; i < 8; i++) xv[i] = -(1 << (IW - 1));
        ev = '{-134217728, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) ev[i] = rnd(ev[i]);
        run_one("s8_min", 1'b1, xv, ev);
        for (int i = 0; i < 8; i++) xv[i] = (i % 2 == 0) ? (1 << (IW - 1)) - 1 : -(1 << (IW - 1));
        model(1'b1, xv, ev);
        run_one("s8_alt", 1'b1, xv, ev);
        model(1'b0, xv, ev);
        run_one("s4_alt", 1'b0, xv, ev);
        for (int i = 0; i < 8; i++) xv[i] = -(1 << (IW - 1));
        model(1'b0, xv, ev);
        run_one("s4_min", 1'b0, xv, ev);

        // Back-to-back alternating sizes with a 5-cycle downstream stall
        nsent = 0;
        nrecv = 0;
        cyc = 0;
        was_stall = 1'b0;
        @(posedge clk); #1;
        while (nrecv < NS && cyc < 300) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            in_valid  = (nsent < NS);
            if (nsent < NS) begin
                in_size8 = nsent[0];
                for (int i = 0; i < 8; i++) in_x[i] = IW'(sv[nsent][i]);
            end
            @(negedge clk);
            if (!out_ready) begin
                check_eq("stall_in_ready", longint'(in_ready), 0);
                check_eq("stall_out_valid", longint'(out_valid), 1);
                if (was_stall)
                    for (int i = 0; i < 8; i++)
                        check_eq($sformatf("stall_hold_y%0d", i), longint'(out_y[i]), held[i]);
                for (int i = 0; i < 8; i++) held[i] = longint'(out_y[i]);
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < 8; i++) xa[i] = sv[nsent][i];
                model(in_size8, xa, ya);
                q_sz.push_back(in_size8);
                for (int i = 0; i < 8; i++) q_y.push_back(ya[i]);
                nsent++;
            end
            if (out_valid && out_ready) begin
                if (q_sz.size() == 0) begin
                    check_eq("strm_unexpected_out", 1, 0);
                end else begin
                    check_eq($sformatf("strm%0d_size8", nrecv), longint'(out_size8), longint'(q_sz.pop_front()));
                    for (int i = 0; i < 8; i++)
                        check_eq($sformatf("strm%0d_y%0d", nrecv, i), longint'(out_y[i]), q_y.pop_front());
                end
                nrecv++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("strm_count", nrecv, NS);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset with three vectors in flight
        in_size8 = 1'b1;
        for (int i = 0; i < 8; i++) in_x[i] = IW'(i + 1);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("pre_rst_out_valid", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", longint'(out_valid), 0);
        check_eq("mid_rst_size8", longint'(out_size8), 0);
        check_eq("mid_rst_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 8; i++) check_eq($sformatf("mid_rst_y%0d", i), longint'(out_y[i]), 0);
        @(negedge clk) rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("post_rst_stale", stale, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dct2_1d_pipe.md
DCT2_1D_PIPE -- requirements
Module: dct2_1d_pipe

Interface
REQ-001 Parameter IW, default 19, signed input sample width.
REQ-002 Parameter OW, default IW+10, signed output coefficient width; OW >= IW+10 SHALL be enforced by elaboration-time assertion.
REQ-003 Parameter SHIFT, default 2, right-shift amount used only when DCT2_ROUND_SHIFT_EN is defined; SHIFT >= 1.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  input vector valid.
REQ-007 in_ready  output  1  block accepts vector this cycle.
REQ-008 in_size8  input  1  1 = 8-point transform, 0 = 4-point.
REQ-009 in_x  input  8 x IW signed  samples X[0..7]; only X[0..3] used when in_size8=0.
REQ-010 out_valid  output  1  output vector valid.
REQ-011 out_ready  input  1  downstream accepts output.
REQ-012 out_size8  output  1  size flag of the current output vector.
REQ-013 out_y  output  8 x OW signed  coefficients Y[0..7] in natural frequency order.

Function
REQ-014 Three register stages S1 (even/odd decomposition), S2 (constant multiplies), S3 (sums); each stage carries a valid bit and a size8 flag.
REQ-015 Global advance = !out_valid || out_ready; all stages load only when advance=1; in_ready SHALL equal advance.
REQ-016 Transfer occurs when in_valid && in_ready; a non-transfer cycle with advance=1 SHALL insert a bubble (valid=0) into S1.
REQ-017 Latency: exactly 3 cycles from input transfer to out_valid with out_ready held high; throughput 1 vector/cycle.
REQ-018 out_valid SHALL stay high and out_y/out_size8 stable while out_ready=0.
REQ-019 Size8: E[i]=X[i]+X[7-i], O[i]=X[i]-X[7-i], i=0..3; EE0=E0+E3, EE1=E1+E2, EO0=E0-E3, EO1=E1-E2.
REQ-020 Size8 even: Y0=64(EE0+EE1), Y4=64(EE0-EE1), Y2=83EO0+36EO1, Y6=36EO0-83EO1.
REQ-021 Size8 odd: Y1=89O0+75O1+50O2+18O3, Y3=75O0-18O1-89O2-50O3, Y5=50O0-89O1+18O2+75O3, Y7=18O0-50O1+75O2-89O3.
REQ-022 Size4: E0=X0+X3, E1=X1+X2, O0=X0-X3, O1=X1-X2; Y0=64(E0+E1), Y2=64(E0-E1), Y1=83O0+36O1, Y3=36O0-83O1; Y4..Y7 SHALL be 0.
REQ-023 In size4 mode, Y[0..3] SHALL be output as 4-point coefficients in natural order (Y0,Y1,Y2,Y3) in lanes 0..3.
REQ-024 All multiplies SHALL be shift-add (no multiplier inference); intermediates full precision, no overflow for any IW-bit input.
REQ-025 Size may change on every vector; no flush between sizes.

Reset
REQ-026 rst_n low SHALL asynchronously clear all stage valid bits, size flags and data registers; out_valid=0, out_y=0, out_size8=0; in_ready=1 during and after reset.
REQ-027 Reset mid-stream SHALL discard all in-flight vectors; no partial output after release.

Configuration
REQ-028 Macro DCT2_ROUND_SHIFT_EN defined: S3 SHALL output (Yraw + (1<<(SHIFT-1))) >>> SHIFT, sign-extended to OW.
REQ-029 Macro undefined: S3 SHALL output Yraw unshifted; SHIFT unused; latency unchanged in both builds.

Structure
REQ-030 Package dct2_pkg SHALL hold coefficient constants (64,83,36,89,75,50,18), default IW, and a typedef for the size flag.
REQ-031 Sub-module sau_8o SHALL compute 89x,75x,50x,18x shift-add products of one odd input; four instances used in S2.

Verification
REQ-032 Size4, X=[1,2,3,4], SHIFT off -> after 3 cycles Y[0..3]=[640,-285,0,-25], Y[4..7]=0, out_size8=0.
REQ-033 Size8, X=[1,0,0,0,0,0,0,0] -> Y=[64,89,83,75,64,50,36,18].
REQ-034 Size8, X all 1 -> Y0=512, Y1..Y7=0; with DCT2_ROUND_SHIFT_EN, SHIFT=2 -> Y0=128.
REQ-035 Back-to-back alternating size4/size8 vectors with out_ready=0 for 5 cycles mid-stream -> in_ready=0 during stall, no loss/duplication, order preserved.
REQ-036 Assert rst_n low with 3 vectors in flight -> out_valid=0 immediately, out_y=0, no stale outputs after release.
REQ-037 Extreme inputs X[i]=-(2^(IW-1)) and alternating max/min -> results match reference model bit-exactly, no wrap.
